// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default block width, round counts for AES-128/AES-256,
// round index width, controller FSM state enum and the NR select helper.
package aes_pkg;

  localparam int DATA_LEN_DEF = 128;
  localparam int NR_128       = 10;
  localparam int NR_256       = 14;
  localparam int RND_W        = 4;

  typedef logic [RND_W-1:0] round_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Final round index for the latched key size.
  function automatic round_t nr_sel(input logic key256, input round_t nr_base);
    return key256 ? round_t'(NR_256) : nr_base;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-side, datapath-side and ciphertext-side signals of the round scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid_in/ready_in on input, valid_out/ready_out on output;
//   the datapath side is strobe based (dp_valid -> dp_valid_out).
// Modports: slave = controller view, master = environment view.
// key_sel is present only when AES_KEY256_EN is defined.
interface aes_round_ctrl_if #(
  parameter int DATA_LEN = aes_pkg::DATA_LEN_DEF
) ();

  // Block input
  logic                      valid_in;
  logic                      ready_in;
  logic [DATA_LEN-1:0]       data_in;
  // Round datapath
  logic                      dp_valid;
  logic [DATA_LEN-1:0]       dp_data;
  logic [aes_pkg::RND_W-1:0] dp_round;
  logic                      dp_first;
  logic                      dp_last;
  logic                      dp_valid_out;
  logic [DATA_LEN-1:0]       dp_data_out;
  // Ciphertext output
  logic                      valid_out;
  logic [DATA_LEN-1:0]       data_out;
  logic                      ready_out;
  logic                      busy;

`ifdef AES_KEY256_EN
  logic                      key_sel;

  modport slave (
    input  valid_in, data_in, dp_valid_out, dp_data_out, ready_out, key_sel,
    output ready_in, dp_valid, dp_data, dp_round, dp_first, dp_last,
           valid_out, data_out, busy
  );

  modport master (
    output valid_in, data_in, dp_valid_out, dp_data_out, ready_out, key_sel,
    input  ready_in, dp_valid, dp_data, dp_round, dp_first, dp_last,
           valid_out, data_out, busy
  );
`else
  modport slave (
    input  valid_in, data_in, dp_valid_out, dp_data_out, ready_out,
    output ready_in, dp_valid, dp_data, dp_round, dp_first, dp_last,
           valid_out, data_out, busy
  );

  modport master (
    output valid_in, data_in, dp_valid_out, dp_data_out, ready_out,
    input  ready_in, dp_valid, dp_data, dp_round, dp_first, dp_last,
           valid_out, data_out, busy
  );
`endif

endinterface

// File: rtl/aes_round_cnt.sv
// Round counter for the AES scheduler: clear, saturating increment, last-round compare.
// Latency: round updates one cycle after clr/inc; is_last/next_last are combinational on the count.
// Backpressure: none; the controller decides when to clear or step.
// Ports: clk, reset (sync, active low), clr (start of block, also latches key_sel),
//   inc (step to next round), key_sel (AES_KEY256_EN builds only),
//   round (current index), is_last (round == NR), next_last (round + 1 == NR).
// Macro AES_KEY256_EN: adds key_sel and the NR select between NR_BASE and 14.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NR_BASE = NR_128
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   inc,
`ifdef AES_KEY256_EN
  input  logic   key_sel,
`endif
  output round_t round,
  output logic   is_last,
  output logic   next_last
);

  localparam round_t NR_B = round_t'(NR_BASE);

  round_t round_q, round_d;
  round_t nr;

`ifdef AES_KEY256_EN
  logic key256_q, key256_d;

  // Key size is captured with the block so NR cannot change mid-block.
  assign nr = nr_sel(key256_q, NR_B);

  always_comb begin
    key256_d = key256_q;
    if (clr) begin
      key256_d = key_sel;
    end
  end
`else
  assign nr = NR_B;
`endif

  // Saturates at NR: the counter never wraps even if inc is held.
  always_comb begin
    round_d = round_q;
    if (clr) begin
      round_d = '0;
    end else if (inc && (round_q != nr)) begin
      round_d = round_q + round_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      round_q  <= '0;
`ifdef AES_KEY256_EN
      key256_q <= 1'b0;
`endif
    end else begin
      round_q  <= round_d;
`ifdef AES_KEY256_EN
      key256_q <= key256_d;
`endif
    end
  end

  assign round     = round_q;
  assign is_last   = (round_q == nr);
  assign next_last = ((round_q + round_t'(1)) == nr);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round scheduler driving one shared round datapath through all rounds of a block.
// Latency: round r issued 1+r*(L+1) cycles after the input handshake; valid_out NR*(L+1)+L+2 cycles after it.
// Backpressure: ready_in only in IDLE; ciphertext held stable in DONE until ready_out.
// Ports: clk, reset (sync, active low), bus (aes_round_ctrl_if.slave):
//   valid_in/ready_in/data_in block input, dp_* round issue and response,
//   valid_out/data_out/ready_out ciphertext, busy, key_sel (AES_KEY256_EN only).
// Macro AES_KEY256_EN: key_sel selects 14 rounds when latched high.
// Every output is a flop; no input reaches an output combinationally.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int NR_BASE  = NR_128
) (
  input  logic            clk,
  input  logic            reset,
  aes_round_ctrl_if.slave bus
);

  ctrl_state_e         state_q, state_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                ready_in_q, ready_in_d;
  logic                busy_q, busy_d;
  logic                dp_valid_q, dp_valid_d;
  logic                dp_first_q, dp_first_d;
  logic                dp_last_q, dp_last_d;
  logic                valid_out_q, valid_out_d;

  logic   cnt_clr;
  logic   cnt_inc;
  round_t round;
  logic   is_last;
  logic   next_last;

  aes_round_cnt #(
    .NR_BASE   (NR_BASE)
  ) u_round_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
`ifdef AES_KEY256_EN
    .key_sel   (bus.key_sel),
`endif
    .round     (round),
    .is_last   (is_last),
    .next_last (next_last)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      IDLE: begin
        // ready_in is registered high whenever we sit in IDLE.
        if (bus.valid_in && ready_in_q) begin
          data_d  = bus.data_in;
          cnt_clr = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Responses are only honoured here; a stray strobe elsewhere
        // (e.g. one still in flight across a reset) is dropped.
        if (bus.dp_valid_out) begin
          data_d = bus.dp_data_out;
          if (is_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (bus.ready_out) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    ready_in_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    dp_valid_d  = (state_d == ISSUE);
    valid_out_d = (state_d == DONE);
    dp_first_d  = (state_q == IDLE) && (state_d == ISSUE);
    // The counter steps on the same edge, so compare against round+1.
    dp_last_d   = (state_q == WAIT) && (state_d == ISSUE) && next_last;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      ready_in_q  <= 1'b1;
      busy_q      <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_first_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ready_in_q  <= ready_in_d;
      busy_q      <= busy_d;
      dp_valid_q  <= dp_valid_d;
      dp_first_q  <= dp_first_d;
      dp_last_q   <= dp_last_d;
      valid_out_q <= valid_out_d;
    end
  end

  // The single state register feeds both the datapath and the ciphertext
  // port; it only changes on a handshake or an accepted response, so
  // data_out is stable for the whole of DONE.
  assign bus.ready_in  = ready_in_q;
  assign bus.busy      = busy_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_data   = data_q;
  assign bus.dp_round  = round;
  assign bus.dp_first  = dp_first_q;
  assign bus.dp_last   = dp_last_q;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_q;

endmodule
